// File: rtl/rcc_lp_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rcc_lp_mode_ctrl
// Brief    : Low-power sequencer: per-domain drain/stop handshake, system
//            stop entry and oscillator-restart wakeup, on the always-on HSI.
// Revision : 1.0 - initial release
// ============================================================================
module rcc_lp_mode_ctrl #(
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int STOP_DELAY  = 4,
    parameter int WAKE_DELAY  = 8
) (
    input  logic hsi_clk,
    input  logic sys_rst,
    input  logic c1_deepsleep,
    input  logic c2_deepsleep,
    input  logic c1_per_alloc_d2,
    input  logic c2_per_alloc_d1,
    input  logic d3_deepsleep,
    input  logic d1_idle_ack,
    input  logic d2_idle_ack,
    input  logic d1_wkup,
    input  logic d2_wkup,
    input  logic osc_rdy,
    output logic d1_stop_req,
    output logic d2_stop_req,
    output logic rcc_d1_stop,
    output logic rcc_d2_stop,
    output logic rcc_sys_stop,
    output logic osc_en,
    output logic sys_clk_sw_force,
    output logic ack_timeout_err
);

    typedef enum logic [1:0] {
        D_RUN  = 2'd0,
        D_REQ  = 2'd1,
        D_STOP = 2'd2
    } dom_state_t;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_ENTRY = 3'd1,
        S_STOP  = 3'd2,
        S_OSC   = 3'd3,
        S_WAKE  = 3'd4
    } sys_state_t;

    localparam logic [CNT_W-1:0] c_ack_last  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stop_last = CNT_W'(STOP_DELAY - 1);
    localparam logic [CNT_W-1:0] c_wake_last = CNT_W'(WAKE_DELAY - 1);

    sys_state_t       r_sys_state;
    sys_state_t       w_sys_nxt;
    logic [CNT_W-1:0] r_sys_cnt;
    logic [CNT_W-1:0] w_sys_cnt_nxt;
    logic             w_sys_run;
    logic             w_any_wkup;

    logic [1:0] w_ok;
    logic [1:0] w_wkup;
    logic [1:0] w_ack;
    logic [1:0] w_dom_stop;
    logic [1:0] w_dom_stop_nxt;
    logic [1:0] w_timeout;
    logic [1:0] w_stop_req;
    logic [1:0] w_rcc_stop;

    logic r_sys_stop;
    logic r_osc_en;
    logic r_sw_force;
    logic r_ack_err;

    // A domain may stop only if the other core is not using its peripherals
    assign w_ok[0]    = c1_deepsleep & (~c2_per_alloc_d1 | c2_deepsleep);
    assign w_ok[1]    = c2_deepsleep & (~c1_per_alloc_d2 | c1_deepsleep);
    assign w_wkup     = {d2_wkup, d1_wkup};
    assign w_ack      = {d2_idle_ack, d1_idle_ack};
    assign w_sys_run  = (r_sys_state == S_RUN);
    assign w_any_wkup = |w_wkup;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dom
        dom_state_t       r_state;
        dom_state_t       w_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic             w_abort;
        logic             w_to;
        logic             r_req;
        logic             r_stop;

        assign w_abort = w_wkup[gi] | ~w_ok[gi];

        always_comb begin
            w_nxt = r_state;
            w_to  = 1'b0;
            case (r_state)
                D_RUN:  if (w_ok[gi] & ~w_wkup[gi]) w_nxt = D_REQ;
                D_REQ: begin
                    if (w_abort)                w_nxt = D_RUN;
                    else if (w_ack[gi])         w_nxt = D_STOP;
                    else if (r_cnt == c_ack_last) begin
                        w_nxt = D_RUN;
                        w_to  = 1'b1;
                    end
                end
                // Held stopped until the system clock is running again
                D_STOP: if (w_abort & w_sys_run) w_nxt = D_RUN;
                default: w_nxt = D_RUN;
            endcase
        end

        always_ff @(posedge hsi_clk) begin
            if (sys_rst) begin
                r_state <= D_RUN;
                r_cnt   <= '0;
                r_req   <= 1'b0;
                r_stop  <= 1'b0;
            end else begin
                r_state <= w_nxt;
                r_cnt   <= (r_state == D_REQ && w_nxt == D_REQ) ? r_cnt + 1'b1 : '0;
                r_req   <= (w_nxt != D_RUN);
                r_stop  <= (w_nxt == D_STOP);
            end
        end

        assign w_dom_stop[gi]     = (r_state == D_STOP);
        assign w_dom_stop_nxt[gi] = (w_nxt == D_STOP);
        assign w_timeout[gi]      = w_to;
        assign w_stop_req[gi]     = r_req;
        assign w_rcc_stop[gi]     = r_stop;
    end

    always_comb begin
        w_sys_nxt     = r_sys_state;
        w_sys_cnt_nxt = '0;
        case (r_sys_state)
            // Entry uses the domains' next state so the delay starts on the
            // same edge the last domain stops
            S_RUN: if ((&w_dom_stop_nxt) & d3_deepsleep) w_sys_nxt = S_ENTRY;
            S_ENTRY: begin
                if (w_any_wkup | ~d3_deepsleep | ~(&w_dom_stop))
                    w_sys_nxt = S_RUN;
                else if (r_sys_cnt == c_stop_last)
                    w_sys_nxt = S_STOP;
                else
                    w_sys_cnt_nxt = r_sys_cnt + 1'b1;
            end
            S_STOP: if (w_any_wkup) w_sys_nxt = S_OSC;
            // Counter non-zero marks that osc_en has been high for a cycle
            S_OSC: begin
                w_sys_cnt_nxt = CNT_W'(1);
                if ((r_sys_cnt != '0) & osc_rdy) begin
                    w_sys_nxt     = S_WAKE;
                    w_sys_cnt_nxt = '0;
                end
            end
            S_WAKE: begin
                if (r_sys_cnt == c_wake_last)
                    w_sys_nxt = S_RUN;
                else
                    w_sys_cnt_nxt = r_sys_cnt + 1'b1;
            end
            default: w_sys_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge hsi_clk) begin
        if (sys_rst) begin
            r_sys_state <= S_RUN;
            r_sys_cnt   <= '0;
            r_sys_stop  <= 1'b0;
            r_osc_en    <= 1'b1;
            r_sw_force  <= 1'b0;
            r_ack_err   <= 1'b0;
        end else begin
            r_sys_state <= w_sys_nxt;
            r_sys_cnt   <= w_sys_cnt_nxt;
            r_sys_stop  <= (w_sys_nxt == S_STOP) || (w_sys_nxt == S_OSC) ||
                           (w_sys_nxt == S_WAKE);
            r_osc_en    <= (w_sys_nxt != S_STOP);
            r_sw_force  <= (r_sys_state == S_WAKE) && (w_sys_nxt == S_RUN);
            r_ack_err   <= |w_timeout;
        end
    end

    assign d1_stop_req      = w_stop_req[0];
    assign d2_stop_req      = w_stop_req[1];
    assign rcc_d1_stop      = w_rcc_stop[0];
    assign rcc_d2_stop      = w_rcc_stop[1];
    assign rcc_sys_stop     = r_sys_stop;
    assign osc_en           = r_osc_en;
    assign sys_clk_sw_force = r_sw_force;
    assign ack_timeout_err  = r_ack_err;

endmodule
`default_nettype wire

// File: doc/rcc_lp_mode_ctrl.md
Name: rcc_lp_mode_ctrl

Overview:
Low-power mode sequencer that produces the domain and system stop controls consumed by the system clock generator. It evaluates the core sleep/deepsleep states and peripheral allocation, then runs a handshake with each domain's bus fabric before stopping that domain's clocks. It stops the system clock only when D1, D2 and D3 all request stop. On wakeup it restarts the oscillator, waits for it to be ready, forces the system clock switch back to HSI, and releases the domains. The block runs on the always-on HSI clock, never on a clock it gates.

Parameters:
CNT_W, 8, width of the shared delay/timeout counter
ACK_TIMEOUT, 64, max cycles in a REQ state waiting for idle ack (must be < 2^CNT_W)
STOP_DELAY, 4, cycles from all-domains-stopped to rcc_sys_stop assertion (>=1)
WAKE_DELAY, 8, cycles after osc_rdy before rcc_sys_stop release (>=1)

Ports:
hsi_clk  in  1  always-on clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
c1_deepsleep  in  1  core 1 in deepsleep
c2_deepsleep  in  1  core 2 in deepsleep
c1_per_alloc_d2  in  1  core 1 owns D2 peripherals
c2_per_alloc_d1  in  1  core 2 owns D1 peripherals
d3_deepsleep  in  1  D3 requests stop
d1_idle_ack  in  1  D1 bus idle, acknowledges stop request
d2_idle_ack  in  1  D2 bus idle, acknowledges stop request
d1_wkup  in  1  D1 wakeup event (level)
d2_wkup  in  1  D2 wakeup event (level)
osc_rdy  in  1  HSI/PLL ready after restart
d1_stop_req  out  1  request to D1 fabric to drain
d2_stop_req  out  1  request to D2 fabric to drain
rcc_d1_stop  out  1  1 = D1 bus clocks stopped
rcc_d2_stop  out  1  1 = D2 bus clocks stopped
rcc_sys_stop  out  1  1 = system clock stopped
osc_en  out  1  oscillator/PLL enable
sys_clk_sw_force  out  1  one-cycle pulse: clock switch reverts to HSI (00)
ack_timeout_err  out  1  one-cycle pulse: idle ack timeout

Behaviour:
- All outputs registered. Reset values: osc_en=1; every other output 0. Domain FSMs reset to RUN; system FSM resets to S_RUN; counter resets to 0.
- d1_ok = c1_deepsleep & (~c2_per_alloc_d1 | c2_deepsleep).
- d2_ok = c2_deepsleep & (~c1_per_alloc_d2 | c1_deepsleep).
- D1 and D2 each have an identical FSM (shown for Dx) with a private counter:
  - RUN -> REQ when dx_ok & ~dx_wkup. In REQ, dx_stop_req=1 and the counter increments each cycle.
  - REQ -> STOP when dx_idle_ack=1. rcc_dx_stop rises the cycle after the ack is sampled.
  - REQ -> RUN when dx_wkup=1 or dx_ok=0. This is an abort; no error.
  - REQ -> RUN when the counter reaches ACK_TIMEOUT-1 without ack. ack_timeout_err pulses for 1 cycle. Abort has priority over timeout in the same cycle.
  - STOP: dx_stop_req stays 1 and rcc_dx_stop=1.
  - STOP -> RUN when (dx_wkup | ~dx_ok) and the system FSM is in S_RUN. Both stop outputs clear on the next cycle.
  - A domain in STOP is held there while the system FSM is outside S_RUN.
- System FSM:
  - S_RUN -> S_ENTRY when both domains are in STOP and d3_deepsleep=1.
  - S_ENTRY counts STOP_DELAY cycles, then -> S_STOP. The abort condition (any wkup, d3_deepsleep=0, or either domain leaving STOP) -> S_RUN; rcc_sys_stop is never asserted on abort.
  - Entering S_STOP sets rcc_sys_stop=1 and osc_en=0 on the same edge.
  - S_STOP -> S_OSC on d1_wkup | d2_wkup; osc_en=1 on entry. Clearing d3_deepsleep alone does not wake.
  - S_OSC -> S_WAKE when osc_rdy=1. osc_rdy is ignored until osc_en has been 1 for at least 1 cycle.
  - S_WAKE counts WAKE_DELAY cycles, then -> S_RUN. On that edge rcc_sys_stop=0 and sys_clk_sw_force pulses 1 for exactly 1 cycle.
  - Domains exit STOP no earlier than the cycle after S_RUN is re-entered.
- Simultaneous events:
  - Wakeup arriving on the same cycle as the final STOP_DELAY count: wake wins (-> S_RUN).
  - Both domains' acks in the same cycle: both go to STOP together.
- Reset mid-sequence (any state): the next cycle all outputs return to reset values, osc_en=1.

Test Plan:
1. Both cores deepsleep, no allocation, d3_deepsleep=1, acks 3 cycles after req -> rcc_d1_stop/rcc_d2_stop=1 one cycle after ack; rcc_sys_stop=1 and osc_en=0 exactly 4 cycles after both are stopped.
2. From S_STOP, pulse d1_wkup, osc_rdy 10 cycles later -> osc_en=1 next cycle; rcc_sys_stop=0 8 cycles after osc_rdy; sys_clk_sw_force high for 1 cycle; rcc_d1_stop=0 the following cycle.
3. c1_deepsleep=1, c2_deepsleep=0, c2_per_alloc_d1=1 -> d1_stop_req stays 0; set c2_deepsleep=1 -> d1_stop_req=1 next cycle.
4. Stop requested, d2_idle_ack never arrives -> ack_timeout_err pulses at cycle 64 of REQ; d2_stop_req=0 next cycle; rcc_d2_stop never 1.
5. d2_wkup asserted in cycle 2 of S_ENTRY -> return to S_RUN, rcc_sys_stop stays 0, osc_en stays 1, D2 returns to RUN.
6. sys_rst asserted in S_OSC -> next cycle rcc_sys_stop=0, osc_en=1, all stop/req outputs 0, no sys_clk_sw_force pulse.
